// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag indices, per-op flag masks, FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int FLG_EQ = 0;
    localparam int FLG_LT = 1;
    localparam int FLG_CF = 2;
    localparam int FLG_OF = 3;

    // Masks are written eq-first: bit 0 (leftmost) is eq.
    localparam logic [0:3] MASK_ARITH = 4'b1111;
    localparam logic [0:3] MASK_LOGIC = 4'b1100;
    localparam logic [0:3] MASK_SHIFT = 4'b1110;
    localparam logic [0:3] MASK_MUL   = 4'b1110;
    localparam logic [0:3] MASK_NONE  = 4'b0000;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle while i_run is high.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic               o_fin
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (i_run) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    // The final step's sum is exposed combinationally so the top can capture it on the finishing edge.
    assign o_prod = w_acc_nxt;
    assign o_fin  = i_run && (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with single-cycle ops and an optional iterative MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise op 7 completes at once with result 0 and no flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [0:3]       new_flags,
    output logic [0:3]       flag_mask
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [0:3]       r_flags;
    logic [0:3]       r_mask;

    logic             w_accept;
    logic             w_mul_go;
    logic             w_mul_fin;
    logic [WIDTH:0]   w_usum;
    logic [WIDTH:0]   w_udif;
    logic [WIDTH-1:0] w_res;
    logic [0:3]       w_flg;
    logic [0:3]       w_msk;

    function automatic logic [0:3] mask_flags(input logic [0:3] f, input logic [0:3] m);
        return f & m;
    endfunction

    assign w_accept = start && (r_state != ST_MUL);
    assign w_usum   = {1'b0, a} + {1'b0, b};
    assign w_udif   = {1'b0, a} - {1'b0, b};

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [0:3]         w_mul_flg;

    assign w_mul_go = w_accept && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .nrst   (nrst),
        .i_load (w_mul_go),
        .i_run  (r_state == ST_MUL),
        .i_a    (a),
        .i_b    (b),
        .o_prod (w_mul_prod),
        .o_fin  (w_mul_fin)
    );

    always_comb begin
        w_mul_flg         = '0;
        w_mul_flg[FLG_EQ] = (w_mul_prod[WIDTH-1:0] == '0);
        w_mul_flg[FLG_LT] = w_mul_prod[WIDTH-1];
        w_mul_flg[FLG_CF] = |w_mul_prod[2*WIDTH-1:WIDTH];
    end
`else
    assign w_mul_go  = 1'b0;
    assign w_mul_fin = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = w_mul_go ? ST_MUL : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_fin) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_flg = '0;
        w_msk = MASK_NONE;
        case (op)
            OP_ADD: begin
                w_res         = w_usum[WIDTH-1:0];
                w_flg[FLG_CF] = w_usum[WIDTH];
                w_flg[FLG_OF] = (a[WIDTH-1] == b[WIDTH-1]) && (w_usum[WIDTH-1] != a[WIDTH-1]);
                w_msk         = MASK_ARITH;
            end
            OP_SUB: begin
                w_res         = w_udif[WIDTH-1:0];
                w_flg[FLG_CF] = w_udif[WIDTH];
                w_flg[FLG_OF] = (a[WIDTH-1] != b[WIDTH-1]) && (w_udif[WIDTH-1] != a[WIDTH-1]);
                w_msk         = MASK_ARITH;
            end
            OP_AND: begin
                w_res = a & b;
                w_msk = MASK_LOGIC;
            end
            OP_OR: begin
                w_res = a | b;
                w_msk = MASK_LOGIC;
            end
            OP_XOR: begin
                w_res = a ^ b;
                w_msk = MASK_LOGIC;
            end
            OP_SHL: begin
                w_res         = {a[WIDTH-2:0], 1'b0};
                w_flg[FLG_CF] = a[WIDTH-1];
                w_msk         = MASK_SHIFT;
            end
            OP_SHR: begin
                w_res         = {1'b0, a[WIDTH-1:1]};
                w_flg[FLG_CF] = a[0];
                w_msk         = MASK_SHIFT;
            end
            default: ;
        endcase
        // For ADD/SUB the true sign of the result is its MSB corrected by overflow.
        w_flg[FLG_LT] = w_res[WIDTH-1] ^ w_flg[FLG_OF];
        w_flg[FLG_EQ] = (w_res == '0);
        w_flg         = mask_flags(w_flg, w_msk);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_result <= '0;
            r_flags  <= '0;
            r_mask   <= '0;
        end else if (w_accept && !w_mul_go) begin
            r_result <= w_res;
            r_flags  <= w_flg;
            r_mask   <= w_msk;
`ifdef ALU_SEQ_MUL_EN
        end else if ((r_state == ST_MUL) && w_mul_fin) begin
            r_result <= w_mul_prod[WIDTH-1:0];
            r_flags  <= mask_flags(w_mul_flg, MASK_MUL);
            r_mask   <= MASK_MUL;
`endif
        end else begin
            r_flags  <= '0;
            r_mask   <= '0;
        end
    end

    assign busy      = (r_state == ST_MUL);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign new_flags = r_flags;
    assign flag_mask = r_mask;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: random and directed ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int     W   = 16;
    localparam longint MOD = longint'(1) << W;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [0:3]   new_flags;
    logic [0:3]   flag_mask;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .new_flags (new_flags),
        .flag_mask (flag_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [0:3]   flg;
        logic [0:3]   msk;
        int           due;
    } exp_t;

    exp_t         q[$];
    exp_t         me;
    int           n_cmp = 0;
    int           n_err = 0;
    int           free_cyc = 0;
    int           mb_lo = 1;
    int           mb_hi = 0;
    logic [W-1:0] last_res = '0;
    bit           mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic longint to_signed(input longint x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    function automatic exp_t model(input int o, input longint x, input longint y, input int now);
        exp_t   e;
        longint r, t;
        bit     eq, lt, cf, of;
        logic [0:3] m;
        int     lat;
        lat = 1; r = 0; cf = 0; of = 0; lt = 0; m = 4'b0000;
        case (o)
            0: begin
                t  = to_signed(x) + to_signed(y);
                r  = (x + y) % MOD;
                cf = (x + y) >= MOD;
                of = (t > MOD / 2 - 1) || (t < -(MOD / 2));
                lt = t < 0;
                m  = 4'b1111;
            end
            1: begin
                t  = to_signed(x) - to_signed(y);
                r  = (x - y + MOD) % MOD;
                cf = x < y;
                of = (t > MOD / 2 - 1) || (t < -(MOD / 2));
                lt = t < 0;
                m  = 4'b1111;
            end
            2: begin r = x & y; m = 4'b1100; end
            3: begin r = x | y; m = 4'b1100; end
            4: begin r = x ^ y; m = 4'b1100; end
            5: begin r = (x * 2) % MOD; cf = x >= MOD / 2; m = 4'b1110; end
            6: begin r = x / 2; cf = (x % 2) == 1; m = 4'b1110; end
            default: begin
                if (MUL_ON) begin
                    t   = x * y;
                    r   = t % MOD;
                    cf  = t >= MOD;
                    m   = 4'b1110;
                    lat = W + 1;
                end
            end
        endcase
        if (o >= 2) lt = r >= MOD / 2;
        eq    = (r == 0);
        e.res = W'(r);
        e.flg = {eq, lt, cf, of} & m;
        e.msk = m;
        e.due = now + lat;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        op    = 3'(o);
        a     = x;
        b     = y;
        start = 1'b1;
        if (cyc >= free_cyc) begin
            e = model(o, longint'(x), longint'(y), cyc);
            q.push_back(e);
            free_cyc = e.due;
            if (o == 7 && MUL_ON) begin
                mb_lo = cyc + 1;
                mb_hi = cyc + W;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        nrst  = 1'b0;
        start = 1'b1;
        op    = 3'd0;
        a     = W'($urandom);
        b     = W'($urandom);
        @(posedge clk);
        #1;
        q.delete();
        mb_lo    = 1;
        mb_hi    = 0;
        last_res = '0;
        free_cyc = 0;
        start    = 1'b0;
        nrst     = 1'b1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(1);
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard when an op is due, otherwise demands idle outputs and a held result.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (cyc >= mb_lo && cyc <= mb_hi));
            if (q.size() > 0 && q[0].due == cyc) begin
                me = q.pop_front();
                chk("done", done, 1);
                chk("result", result, me.res);
                chk("flags", new_flags, me.flg);
                chk("mask", flag_mask, me.msk);
                last_res = me.res;
            end else begin
                chk("done_idle", done, 0);
                chk("result_hold", result, last_res);
                chk("mask_idle", flag_mask, 0);
                chk("flags_idle", new_flags, 0);
            end
        end
    end

    initial begin
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(1);
        nrst = 1'b1;

        issue(0, 16'h7FFF, 16'h0001);
        idle(1);
        issue(1, 16'd5, 16'd5);
        issue(1, 16'd3, 16'd5);
        idle(2);
        issue(6, 16'h0003, 16'h0000);
        issue(4, 16'hA5A5, 16'hA5A5);
        idle(1);
        issue(7, 16'h0100, 16'h0100);
        idle(2);
        issue(0, 16'h0001, 16'h0002);
        idle(W + 2);
        issue(7, 16'd3, 16'd4);
        idle(4);
        do_reset();
        idle(W + 3);

        repeat (300) begin
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset();
            issue($urandom_range(0, 7), pick(), pick());
        end

        idle(W + 4);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (>= 4).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port nrst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-006 SHALL have port a, b  input  WIDTH  operands.
REQ-007 SHALL have port busy  output  1  high while an accepted MUL is iterating.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result  output  WIDTH  last completed result, held until next done.
REQ-010 SHALL have port new_flags  output  [0:3]  {eq, lt, cf, of}, bit 0 = eq.
REQ-011 SHALL have port flag_mask  output  [0:3]  per-flag write enable for the flag store, bit 0 = eq.

Function
REQ-012 SHALL implement states IDLE, MUL, DONE; busy=1 only in MUL; done=1 only in DONE.
REQ-013 SHALL accept start in IDLE or DONE; it latches op, a, b on that edge. Start in MUL is ignored with no side effect.
REQ-014 Non-MUL ops SHALL go to DONE on the next edge; latency 1 cycle start->done.
REQ-015 MUL SHALL iterate shift-add for WIDTH cycles in MUL, then go to DONE; latency WIDTH+1 cycles; result = low WIDTH bits of the product.
REQ-016 DONE SHALL return to IDLE without start; with start it accepts the new op (back-to-back issue).
REQ-017 flag_mask SHALL be 4'b0000 in every cycle except DONE, so each op updates the flag store exactly once.
REQ-018 eq SHALL be result==0 for all ops.
REQ-019 ADD/SUB: mask 1111; cf = carry out (ADD) or borrow (SUB, a<b unsigned); of = signed overflow; lt = result MSB xor of.
REQ-020 AND/OR/XOR: mask 1100; lt = result MSB.
REQ-021 SHL/SHR (1-bit, zero fill): mask 1110; cf = bit shifted out; lt = result MSB.
REQ-022 MUL: mask 1110; cf = 1 iff the upper WIDTH product bits are nonzero; lt = result MSB.
REQ-023 new_flags bits with a mask bit of 0 SHALL be driven 0.

Reset
REQ-024 On a clk edge with nrst=0: state IDLE; busy, done, result, new_flags, flag_mask all 0; iteration counter and partial product cleared.
REQ-025 Reset mid-MUL SHALL abort the operation with no done pulse; start in that cycle is ignored.

Configuration
REQ-026 With macro ALU_SEQ_MUL_EN defined, MUL SHALL behave per REQ-015/REQ-022.
REQ-027 Without ALU_SEQ_MUL_EN, no multiplier logic SHALL exist; op 7 completes in 1 cycle with result 0 and flag_mask 0000.

Structure
REQ-028 Opcode encodings, flag index constants (EQ=0, LT=1, CF=2, OF=3), per-op mask constants and state encoding SHALL live in shared package alu_pkg.
REQ-029 The iterative multiplier SHALL be sub-module alu_mul_iter (start, operands, counter, partial product, finish pulse), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=16)
REQ-030 ADD a=0x7FFF b=0x0001 -> done one cycle later, result 0x8000, new_flags eq0 lt0 cf0 of1, mask 1111.
REQ-031 SUB a=5 b=5 -> result 0, flags eq1 lt0 cf0 of0; then back-to-back SUB a=3 b=5 issued in the DONE cycle -> result 0xFFFE, eq0 lt1 cf1 of0.
REQ-032 MUL a=0x0100 b=0x0100 -> busy high 16 cycles, done exactly 17 cycles after start, result 0x0000, flags eq1 lt0 cf1, mask 1110; start with op ADD during busy -> ignored.
REQ-033 SHR a=0x0003 -> result 0x0001, cf1, mask 1110; XOR a=b=0xA5A5 -> result 0, eq1, mask 1100.
REQ-034 nrst low at cycle 5 of a MUL -> next cycle busy0 done0 result 0 mask 0000; no done pulse follows.
REQ-035 Build without ALU_SEQ_MUL_EN: MUL a=3 b=4 -> done after 1 cycle, result 0, mask 0000.
